// File: rtl/pc_sequencer.sv
// Program-counter fetch/issue sequencer: fetches one word per PC from instruction
// memory, holds it for the consumer, and advances sequentially or by redirect on accept.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned STEP         = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ack,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        addr_err,
  output logic [31:0] retired_count
);

  // state | meaning
  // IDLE  | post-reset bubble, no request or valid
  // FETCH | imem_req high at PC, wait for imem_ready
  // ISSUE | instr_valid high, wait for instr_ack
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;

  localparam logic [31:0] STEP_W = 32'(STEP);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [31:0] retired_q, retired_d;
  logic        addr_err_q, addr_err_d;
  logic [31:0] target;
  logic        redirect;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    retired_d  = retired_q;
    addr_err_d = 1'b0;
    target     = 32'h0;
    redirect   = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_ready) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc_q;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (instr_ack) begin
          retired_d = retired_q + 32'd1;
          state_d   = FETCH;
          if (jump) begin
            target   = jump_target;
            redirect = 1'b1;
          end else if (branch_taken) begin
            target   = branch_target;
            redirect = 1'b1;
          end
          // Misaligned redirects are truncated to a word boundary and flagged once.
          if (redirect) begin
            pc_d       = {target[31:2], 2'b00};
            addr_err_d = |target[1:0];
          end else begin
            pc_d = pc_q + STEP_W;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_VECTOR;
      instr_q    <= 32'h0;
      instr_pc_q <= 32'h0;
      retired_q  <= 32'h0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      retired_q  <= retired_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign imem_req      = (state_q == FETCH);
  assign imem_addr     = pc_q;
  assign instr_valid   = (state_q == ISSUE);
  assign instr         = instr_q;
  assign instr_pc      = instr_pc_q;
  assign addr_err      = addr_err_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a vector table walked one cycle per row plus
// hand sequences for reset; a second instance covers the wrapping reset vector.
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_ready, instr_ack, branch_taken, jump;
  logic [31:0] imem_rdata, branch_target, jump_target;

  logic        a_req, a_valid, a_err;
  logic [31:0] a_addr, a_instr, a_ipc, a_ret;
  logic        b_req, b_valid, b_err;
  logic [31:0] b_addr, b_instr, b_ipc, b_ret;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  pc_sequencer #(.RESET_VECTOR(32'h0000_0000), .STEP(4)) dut_a (
    .clock(clock), .reset(reset),
    .imem_req(a_req), .imem_addr(a_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr_valid(a_valid), .instr(a_instr), .instr_pc(a_ipc), .instr_ack(instr_ack),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .addr_err(a_err), .retired_count(a_ret)
  );

  pc_sequencer #(.RESET_VECTOR(32'hFFFF_FFFC), .STEP(4)) dut_b (
    .clock(clock), .reset(reset),
    .imem_req(b_req), .imem_addr(b_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr_valid(b_valid), .instr(b_instr), .instr_pc(b_ipc), .instr_ack(instr_ack),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .addr_err(b_err), .retired_count(b_ret)
  );

  typedef struct {
    logic        rdy;
    logic [31:0] rdata;
    logic        ack;
    logic        br;
    logic [31:0] bt;
    logic        jmp;
    logic [31:0] jt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
    logic        e_err;
    logic [31:0] e_ret;
    logic        b_chk;
    logic [31:0] b_addr;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(input logic rdy, input logic [31:0] rdata, input logic ack,
                              input logic br, input logic [31:0] bt,
                              input logic jmp, input logic [31:0] jt,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_valid, input logic [31:0] e_instr,
                              input logic [31:0] e_ipc, input logic e_err,
                              input logic [31:0] e_ret);
    vec_t v;
    v.rdy = rdy; v.rdata = rdata; v.ack = ack; v.br = br; v.bt = bt;
    v.jmp = jmp; v.jt = jt; v.e_req = e_req; v.e_addr = e_addr;
    v.e_valid = e_valid; v.e_instr = e_instr; v.e_ipc = e_ipc;
    v.e_err = e_err; v.e_ret = e_ret; v.b_chk = 1'b0; v.b_addr = 32'h0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic req, input logic [31:0] addr,
                       input logic valid, input logic [31:0] ins, input logic [31:0] ipc,
                       input logic err, input logic [31:0] ret);
    chk({tag, ".imem_req"},      32'(a_req),   32'(req));
    chk({tag, ".imem_addr"},     a_addr,       addr);
    chk({tag, ".instr_valid"},   32'(a_valid), 32'(valid));
    chk({tag, ".instr"},         a_instr,      ins);
    chk({tag, ".instr_pc"},      a_ipc,        ipc);
    chk({tag, ".addr_err"},      32'(a_err),   32'(err));
    chk({tag, ".retired_count"}, a_ret,        ret);
  endtask

  task automatic idle_inputs();
    imem_ready = 0; imem_rdata = 0; instr_ack = 0;
    branch_taken = 0; branch_target = 0; jump = 0; jump_target = 0;
  endtask

  initial begin
    // rdy rdata ack br bt jmp jt | req addr valid instr ipc err ret
    vecs[0]  = mk(1, 32'hA0, 1, 0, 0, 0, 0,             0, 32'h0,   0, 32'h0,  32'h0,   0, 0);
    vecs[1]  = mk(1, 32'h11, 1, 0, 0, 0, 0,             1, 32'h0,   0, 32'h0,  32'h0,   0, 0);
    vecs[2]  = mk(1, 32'hEE, 1, 0, 0, 0, 0,             0, 32'h0,   1, 32'h11, 32'h0,   0, 0);
    vecs[3]  = mk(1, 32'h22, 1, 0, 0, 0, 0,             1, 32'h4,   0, 32'h11, 32'h0,   0, 1);
    vecs[4]  = mk(1, 32'hEE, 1, 0, 0, 0, 0,             0, 32'h4,   1, 32'h22, 32'h4,   0, 1);
    vecs[5]  = mk(1, 32'h33, 1, 0, 0, 0, 0,             1, 32'h8,   0, 32'h22, 32'h4,   0, 2);
    vecs[6]  = mk(1, 32'hEE, 1, 0, 0, 0, 0,             0, 32'h8,   1, 32'h33, 32'h8,   0, 2);
    for (int i = 7; i < 12; i++)
      vecs[i] = mk(0, 32'h44, 1, 1, 32'h300, 1, 32'h500, 1, 32'hC, 0, 32'h33, 32'h8,   0, 3);
    vecs[12] = mk(1, 32'h55, 0, 0, 0, 0, 0,             1, 32'hC,   0, 32'h33, 32'h8,   0, 3);
    vecs[13] = mk(0, 32'h0,  0, 0, 0, 1, 32'h123,       0, 32'hC,   1, 32'h55, 32'hC,   0, 3);
    vecs[14] = mk(1, 32'h99, 1, 1, 32'h200, 1, 32'h100, 0, 32'hC,   1, 32'h55, 32'hC,   0, 3);
    vecs[15] = mk(1, 32'h66, 0, 0, 0, 0, 0,             1, 32'h100, 0, 32'h55, 32'hC,   0, 4);
    vecs[16] = mk(0, 32'h0,  1, 1, 32'h42, 0, 0,        0, 32'h100, 1, 32'h66, 32'h100, 0, 4);
    vecs[17] = mk(0, 32'h0,  0, 0, 0, 0, 0,             1, 32'h40,  0, 32'h66, 32'h100, 1, 5);
    vecs[18] = mk(1, 32'h77, 0, 0, 0, 0, 0,             1, 32'h40,  0, 32'h66, 32'h100, 0, 5);
    vecs[19] = mk(0, 32'h0,  1, 0, 0, 1, 32'h103,       0, 32'h40,  1, 32'h77, 32'h40,  0, 5);
    vecs[20] = mk(0, 32'h0,  0, 0, 0, 0, 0,             1, 32'h100, 0, 32'h77, 32'h40,  1, 6);
    vecs[21] = mk(0, 32'h0,  0, 0, 0, 0, 0,             1, 32'h100, 0, 32'h77, 32'h40,  0, 6);
    vecs[1].b_chk = 1; vecs[1].b_addr = 32'hFFFF_FFFC;
    vecs[3].b_chk = 1; vecs[3].b_addr = 32'h0000_0000;

    idle_inputs();
    reset = 1;
    repeat (2) @(negedge clock);
    chk_a("reset", 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0);
    chk("reset.b_imem_addr", b_addr, 32'hFFFF_FFFC);
    reset = 0;

    for (int i = 0; i < 22; i++) begin
      chk_a($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
            vecs[i].e_instr, vecs[i].e_ipc, vecs[i].e_err, vecs[i].e_ret);
      if (vecs[i].b_chk) begin
        chk($sformatf("vec%0d.b_imem_addr", i), b_addr, vecs[i].b_addr);
        chk($sformatf("vec%0d.b_addr_err", i), 32'(b_err), 32'h0);
      end
      imem_ready = vecs[i].rdy;  imem_rdata = vecs[i].rdata;
      instr_ack = vecs[i].ack;   branch_taken = vecs[i].br;
      branch_target = vecs[i].bt; jump = vecs[i].jmp; jump_target = vecs[i].jt;
      @(negedge clock);
    end

    // Reset while waiting in FETCH, then a late imem_ready during IDLE is ignored.
    idle_inputs();
    reset = 1;
    @(negedge clock);
    chk_a("midfetch_reset", 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0);
    chk("midfetch_reset.b_imem_addr", b_addr, 32'hFFFF_FFFC);
    reset = 0;
    imem_ready = 1; imem_rdata = 32'hDD;
    @(negedge clock);
    chk_a("after_reset", 1, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0);
    chk("after_reset.b_imem_addr", b_addr, 32'hFFFF_FFFC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter STEP, default 4, sequential PC increment in bytes.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 Ports SHALL be:
- clock  in  1  sole clock, all state updates on rising edge
- reset  in  1  synchronous active-high reset
- imem_req  out  1  instruction memory read request
- imem_addr  out  32  fetch address, equals current PC
- imem_ready  in  1  memory returns imem_rdata this cycle
- imem_rdata  in  32  fetched instruction word
- instr_valid  out  1  instr/instr_pc hold a valid instruction
- instr  out  32  issued instruction word
- instr_pc  out  32  address of issued instruction
- instr_ack  in  1  consumer accepts issued instruction
- branch_taken  in  1  redirect to branch_target on accept
- branch_target  in  32  branch destination
- jump  in  1  redirect to jump_target on accept
- jump_target  in  32  jump destination
- addr_err  out  1  one-cycle pulse: misaligned redirect target
- retired_count  out  32  number of accepted instructions

Function
REQ-005 SHALL implement FSM states IDLE, FETCH, ISSUE; the internal PC register SHALL be 32 bits.
REQ-006 IDLE: all request/valid outputs low; SHALL go to FETCH on the next clock.
REQ-007 FETCH: imem_req=1, imem_addr=PC; on imem_ready=1, SHALL capture imem_rdata into instr and PC into instr_pc, then go to ISSUE; otherwise remain in FETCH with PC unchanged.
REQ-008 imem_req SHALL be asserted only in FETCH; imem_addr SHALL remain stable while imem_req=1 and imem_ready=0.
REQ-009 ISSUE: instr_valid=1; instr and instr_pc SHALL stay stable until instr_ack=1.
REQ-010 On instr_ack=1 in ISSUE, the FSM SHALL update PC, increment retired_count, and go to FETCH; instr_valid drops the following cycle.
REQ-011 Next-PC priority on accept SHALL be:
- jump=1 selects jump_target
- else branch_taken=1 selects branch_target
- else PC+STEP
REQ-012 branch_taken, jump and the targets SHALL be sampled only in ISSUE with instr_ack=1; they are ignored at all other times.
REQ-013 If the selected redirect target has bits [1:0] nonzero, the PC SHALL load the target with bits [1:0] forced to 0, and addr_err SHALL pulse high for exactly one cycle.
REQ-014 PC+STEP SHALL wrap modulo 2^32 (0xFFFFFFFC+4 = 0x00000000), with no error flagged.
REQ-015 retired_count SHALL wrap from 0xFFFFFFFF to 0.
REQ-016 instr_ack asserted outside ISSUE SHALL have no effect.
REQ-017 Fetch-to-issue latency SHALL be 1 cycle after imem_ready; minimum loop is 2 cycles per instruction (FETCH with imem_ready=1, ISSUE with instr_ack=1).

Reset
REQ-018 When reset=1 at a clock edge:
- PC=RESET_VECTOR, state=IDLE
- imem_req=0, instr_valid=0, addr_err=0
- instr=0, instr_pc=0, retired_count=0
REQ-019 Reset SHALL take priority over every other input in any state, including mid-FETCH or mid-ISSUE; a pending fetch is abandoned, and a late imem_ready is ignored while not in FETCH.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset, imem_ready=1, instr_ack=1 always -> imem_addr sequence 0x0, 0x4, 0x8; retired_count 1, 2, 3.
- imem_ready held low 5 cycles in FETCH -> imem_req high, imem_addr constant for 5 cycles, then instr = imem_rdata on ISSUE.
- ISSUE with jump=1 (0x100) and branch_taken=1 (0x200), instr_ack=1 -> next imem_addr=0x100.
- branch_taken=1, target 0x00000042 on accept -> next imem_addr=0x40, addr_err high exactly one cycle.
- RESET_VECTOR=0xFFFFFFFC, sequential accept -> next imem_addr=0x00000000, addr_err=0.
- reset=1 during FETCH wait, then released -> IDLE one cycle, then imem_addr=RESET_VECTOR, retired_count=0.
